// File: rtl/serial_mag_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : serial_mag_cmp_pkg
//  Purpose : Shared definitions for the bit-serial magnitude comparator:
//            FSM state encoding, one-hot result encoding and a helper that
//            packs the compare-cell outputs into that encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package serial_mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Result vector layout is {gt, lt, eq}; all-zero means "no result".
  localparam logic [2:0] c_RES_NONE = 3'b000;
  localparam logic [2:0] c_RES_EQ   = 3'b001;
  localparam logic [2:0] c_RES_LT   = 3'b010;
  localparam logic [2:0] c_RES_GT   = 3'b100;

  function automatic logic [2:0] res_from_cell(input logic eq,
                                               input logic lt,
                                               input logic gt);
    return {gt, lt, eq};
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_mag_cmp_bit_cell.sv
`default_nettype none
// ============================================================================
//  Module  : cmp_bit_cell
//  Purpose : 1-bit magnitude compare cell; exactly one output is high.
//  Ports   : i_a  - bit of operand A
//            i_b  - bit of operand B
//            o_eq - i_a == i_b
//            o_lt - i_a <  i_b
//            o_gt - i_a >  i_b
//  Rev     : 1.0  initial release
// ============================================================================
module cmp_bit_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_eq,
  output logic o_lt,
  output logic o_gt
);

  assign o_eq = ~(i_a ^ i_b);
  assign o_lt = ~i_a &  i_b;
  assign o_gt =  i_a & ~i_b;

endmodule
`default_nettype wire

// File: rtl/serial_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module  : serial_mag_cmp
//  Purpose : Bit-serial unsigned magnitude comparator, MSB first, one bit
//            per cycle through a single 1-bit compare cell. Valid/ready
//            handshake on both sides; result held until consumed.
//  Ports   : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            in_valid  - operand pair offered
//            in_ready  - block idle, can accept operands
//            A, B      - unsigned operands, WIDTH bits
//            out_valid - result available (HOLD state)
//            out_ready - consumer takes result
//            Eq/Lt/Gt  - registered one-hot result, zero outside HOLD
//  Config  : SERIAL_MAG_CMP_EARLY_EXIT_EN - when defined, SHIFT ends the
//            cycle after the first differing bit instead of always running
//            WIDTH cycles.
//  Rev     : 1.0  initial release
// ============================================================================
module serial_mag_cmp
  import serial_mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Eq,
  output logic             Lt,
  output logic             Gt
);

  localparam int c_CW = $clog2(WIDTH);

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
  localparam bit c_EARLY_EXIT = 1'b1;
`else
  localparam bit c_EARLY_EXIT = 1'b0;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [c_CW-1:0]   r_cnt;
  logic [2:0]        r_res;   // first difference seen so far, NONE if none
  logic [2:0]        r_out;   // result presented on Eq/Lt/Gt

  logic              w_eq;
  logic              w_lt;
  logic              w_gt;
  logic              w_decided;
  logic              w_done;
  logic [2:0]        w_final;

  // Operands shift left, so the bit under test is always the top bit.
  cmp_bit_cell u_cell (
    .i_a  (r_a[WIDTH-1]),
    .i_b  (r_b[WIDTH-1]),
    .o_eq (w_eq),
    .o_lt (w_lt),
    .o_gt (w_gt)
  );

  assign w_decided = (r_res != c_RES_NONE);

  // An earlier difference dominates; otherwise the current bit decides,
  // and a still-equal final bit yields EQ.
  assign w_final = w_decided ? r_res : res_from_cell(w_eq, w_lt, w_gt);

  // Early exit fires on the first difference only; a decided result
  // never reaches SHIFT again in that build.
  assign w_done = (r_cnt == '0) || (c_EARLY_EXIT && !w_decided && !w_eq);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = SHIFT;
      SHIFT:   if (w_done)    w_state_nxt = HOLD;
      HOLD:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_res <= c_RES_NONE;
      r_out <= c_RES_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= B;
            r_cnt <= c_CW'(WIDTH - 1);
            r_res <= c_RES_NONE;
          end
        end
        SHIFT: begin
          r_a   <= r_a << 1;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt - 1'b1;
          if (!w_decided && !w_eq) begin
            r_res <= res_from_cell(w_eq, w_lt, w_gt);
          end
          if (w_done) begin
            r_out <= w_final;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out <= c_RES_NONE;
          end
        end
        default: begin
          r_out <= c_RES_NONE;
        end
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == HOLD);
  assign {Gt, Lt, Eq} = r_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module  : tb_serial_mag_cmp
//  Purpose : Directed self-checking bench for serial_mag_cmp, one WIDTH=8
//            instance and one WIDTH=2 instance. Latency expectations follow
//            SERIAL_MAG_CMP_EARLY_EXIT_EN when defined.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_serial_mag_cmp;

`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
  localparam bit c_EARLY = 1'b1;
`else
  localparam bit c_EARLY = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       Eq, Lt, Gt;

  logic       in_valid_w2  = 1'b0;
  logic       in_ready_w2;
  logic [1:0] A_w2 = 2'd0;
  logic [1:0] B_w2 = 2'd0;
  logic       out_valid_w2;
  logic       out_ready_w2 = 1'b0;
  logic       Eq_w2, Lt_w2, Gt_w2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_mag_cmp #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Eq        (Eq),
    .Lt        (Lt),
    .Gt        (Gt)
  );

  serial_mag_cmp #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_w2),
    .in_ready  (in_ready_w2),
    .A         (A_w2),
    .B         (B_w2),
    .out_valid (out_valid_w2),
    .out_ready (out_ready_w2),
    .Eq        (Eq_w2),
    .Lt        (Lt_w2),
    .Gt        (Gt_w2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {gt, lt, eq}
  function automatic logic [2:0] model_res(input logic [7:0] a, input logic [7:0] b);
    if (a > b)      return 3'b100;
    else if (a < b) return 3'b010;
    else            return 3'b001;
  endfunction

  // Cycles from accept edge to first out_valid cycle.
  function automatic int model_lat(input logic [7:0] a, input logic [7:0] b, input int w);
    int dpos;
    dpos = -1;
    for (int i = 0; i < w; i++) begin
      if (a[i] != b[i]) dpos = i;   // highest differing bit wins
    end
    return (c_EARLY && dpos >= 0) ? (w - dpos + 1) : (w + 1);
  endfunction

  // Called at a negedge; offers the pair so the next posedge accepts it.
  task automatic start(input logic [7:0] a, input logic [7:0] b);
    int g;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("start_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
  endtask

  // Follows an accepted pair to its result; optionally consumes it.
  task automatic collect(input logic [7:0] a, input logic [7:0] b,
                         input string tag, input bit release_it);
    int k;
    int lat;
    k   = 0;
    lat = 0;
    while (lat == 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        in_valid = 1'b0;
        A = ~a;          // in-flight result must not see these
        B = a ^ b ^ 8'h5C;
      end
      if (out_valid) lat = k;
    end
    check({tag, "_lat"}, lat, model_lat(a, b, 8));
    check({tag, "_res"}, {29'd0, Gt, Lt, Eq}, {29'd0, model_res(a, b)});
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    if (release_it) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_clr"}, {28'd0, out_valid, Gt, Lt, Eq}, 32'd0);
      check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input string tag);
    start(a, b);
    collect(a, b, tag, 1'b1);
  endtask

  task automatic check_no_stale(input string tag);
    int cnt;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || Eq || Lt || Gt) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    int k;
    int lat;
    int g;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_outs",   {28'd0, out_valid, Gt, Lt, Eq}, 32'd0);
    check("rst_ready2", {31'd0, in_ready_w2}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Main function
    op(8'h5A, 8'h5A, "eq5a");
    op(8'h80, 8'h7F, "gt80");
    op(8'h12, 8'h13, "lt12");
    op(8'hFF, 8'h00, "gtff");
    op(8'h00, 8'hFF, "lt00");
    op(8'h00, 8'h00, "eq00");
    op(8'hA5, 8'hA4, "gta5");
    op(8'h3C, 8'h4C, "lt3c");

    // Held result with back-pressure and a new pair waiting
    start(8'hC3, 8'h3C);
    collect(8'hC3, 8'h3C, "hold", 1'b0);
    in_valid = 1'b1;
    A = 8'h01;
    B = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_res",   {29'd0, Gt, Lt, Eq}, 32'h4);
      check("hold_busy",  {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_rel_idle", {31'd0, in_ready}, 32'd1);
    check("hold_rel_outs", {28'd0, out_valid, Gt, Lt, Eq}, 32'd0);
    collect(8'h01, 8'h02, "hold_next", 1'b1);

    // Reset in SHIFT cycle t+4
    start(8'h12, 8'h13);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_shift_outs",  {28'd0, out_valid, Gt, Lt, Eq}, 32'd0);
    check("rst_shift_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_no_stale("rst_shift_stale");

    // Reset while a result is held
    start(8'h80, 8'h7F);
    collect(8'h80, 8'h7F, "pre_rst", 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_hold_outs",  {28'd0, out_valid, Gt, Lt, Eq}, 32'd0);
    check("rst_hold_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_no_stale("rst_hold_stale");
    op(8'h7E, 8'h7E, "post_rst");

    // WIDTH=2: all 16 pairs back-to-back
    out_ready_w2 = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        g = 0;
        while (!in_ready_w2 && g < 20) begin
          @(negedge clk);
          g++;
        end
        A_w2 = a[1:0];
        B_w2 = b[1:0];
        in_valid_w2 = 1'b1;
        k   = 0;
        lat = 0;
        while (lat == 0 && k < 20) begin
          @(negedge clk);
          k++;
          if (out_valid_w2) lat = k;
        end
        check($sformatf("w2_%0d_%0d_lat", a, b), lat,
              model_lat({6'd0, a[1:0]}, {6'd0, b[1:0]}, 2));
        check($sformatf("w2_%0d_%0d_res", a, b), {29'd0, Gt_w2, Lt_w2, Eq_w2},
              {29'd0, model_res({6'd0, a[1:0]}, {6'd0, b[1:0]})});
      end
    end
    in_valid_w2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w2_end_idle", {28'd0, out_valid_w2, Gt_w2, Lt_w2, Eq_w2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
